// File: rtl/axis_icrc_append.sv
// Forwards the unmasked RoCEv2 stream and appends the ICRC (CRC32 over the masked copy)
// after the last valid byte. Define ICRC_DUMMY_LRH_EN to seed the CRC with the dummy-LRH prefix.
module axis_icrc_append #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_axis_masked_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_masked_tkeep,
    input  logic                    s_axis_masked_tvalid,
    output logic                    s_axis_masked_tready,
    input  logic                    s_axis_masked_tlast,
    input  logic [USER_WIDTH-1:0]   s_axis_masked_tuser,
    input  logic [DATA_WIDTH-1:0]   s_axis_not_masked_tdata,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [USER_WIDTH-1:0]   m_axis_tuser
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'd0, b};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] crc_beat(input logic [31:0] crc,
                                             input logic [DATA_WIDTH-1:0] data,
                                             input logic [KEEP_WIDTH-1:0] keep);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            if (keep[i]) c = crc_byte(c, data[8*i +: 8]);
        end
        return c;
    endfunction

`ifdef ICRC_DUMMY_LRH_EN
    // The 8-byte all-ones dummy LRH is folded into a constant seed, so it costs no cycles.
    function automatic logic [31:0] dummy_lrh_seed();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 8; i++) c = crc_byte(c, 8'hFF);
        return c;
    endfunction
    localparam logic [31:0] SEED = dummy_lrh_seed();
`else
    localparam logic [31:0] SEED = 32'hFFFFFFFF;
`endif

    typedef enum logic {ST_PASS, ST_SPILL} state_t;

    state_t                  state_q, state_d;
    logic [31:0]             crc_q, crc_d;
    logic [31:0]             crc_final, icrc, icrc_shift;
    logic [31:0]             spill_data_q, spill_data_d;
    logic [3:0]              spill_keep_q, spill_keep_d;
    logic [USER_WIDTH-1:0]   spill_user_q, spill_user_d;
    logic                    ready_q, ready_early;
    logic                    in_fire, push_req;
    logic [DATA_WIDTH-1:0]   beat_data;
    logic [KEEP_WIDTH-1:0]   beat_keep;
    logic                    beat_last;
    logic [USER_WIDTH-1:0]   beat_user;
    int                      n_bytes;

    logic                    out_valid_q, skid_valid_q;
    logic [DATA_WIDTH-1:0]   out_data_q, skid_data_q;
    logic [KEEP_WIDTH-1:0]   out_keep_q, skid_keep_q;
    logic                    out_last_q, skid_last_q;
    logic [USER_WIDTH-1:0]   out_user_q, skid_user_q;

    assign s_axis_masked_tready = ready_q && (state_q == ST_PASS) && !rst;
    assign in_fire = s_axis_masked_tvalid && s_axis_masked_tready;
    assign ready_early = m_axis_tready || (!skid_valid_q && (!out_valid_q || !push_req));

    always_comb begin
        state_d      = state_q;
        crc_d        = crc_q;
        spill_data_d = spill_data_q;
        spill_keep_d = spill_keep_q;
        spill_user_d = spill_user_q;
        push_req     = 1'b0;
        beat_data    = '0;
        beat_keep    = '0;
        beat_last    = 1'b0;
        beat_user    = '0;
        icrc_shift   = '0;
        n_bytes      = 0;
        crc_final    = crc_beat(crc_q, s_axis_masked_tdata, s_axis_masked_tkeep);
        icrc         = ~crc_final;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            if (s_axis_masked_tkeep[i]) n_bytes++;
        end

        case (state_q)
            ST_PASS: begin
                push_req  = s_axis_masked_tvalid;
                beat_keep = s_axis_masked_tkeep;
                beat_user = s_axis_masked_tuser;
                for (int i = 0; i < KEEP_WIDTH; i++) begin
                    if (s_axis_masked_tkeep[i]) beat_data[8*i +: 8] = s_axis_not_masked_tdata[8*i +: 8];
                end
                if (s_axis_masked_tlast) begin
                    // ICRC bytes that fit go right after the payload; the rest spill over.
                    for (int i = 0; i < KEEP_WIDTH; i++) begin
                        if (i >= n_bytes && i < n_bytes + 4) begin
                            icrc_shift          = icrc >> (8 * (i - n_bytes));
                            beat_data[8*i +: 8] = icrc_shift[7:0];
                            beat_keep[i]        = 1'b1;
                        end
                    end
                    beat_last = (n_bytes <= KEEP_WIDTH - 4);
                    if (in_fire) begin
                        crc_d = SEED;
                        if (n_bytes > KEEP_WIDTH - 4) begin
                            state_d      = ST_SPILL;
                            spill_data_d = icrc >> (8 * (KEEP_WIDTH - n_bytes));
                            spill_keep_d = 4'((1 << (n_bytes + 4 - KEEP_WIDTH)) - 1);
                            spill_user_d = s_axis_masked_tuser;
                        end
                    end
                end else if (in_fire) begin
                    crc_d = crc_final;
                end
            end
            ST_SPILL: begin
                push_req  = 1'b1;
                beat_data = DATA_WIDTH'(spill_data_q);
                beat_keep = KEEP_WIDTH'(spill_keep_q);
                beat_last = 1'b1;
                beat_user = spill_user_q;
                if (ready_q) state_d = ST_PASS;
            end
            default: state_d = ST_PASS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_PASS;
            crc_q        <= SEED;
            spill_data_q <= '0;
            spill_keep_q <= '0;
            spill_user_q <= '0;
            ready_q      <= 1'b1;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_last_q   <= 1'b0;
            out_user_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_keep_q  <= '0;
            skid_last_q  <= 1'b0;
            skid_user_q  <= '0;
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            spill_data_q <= spill_data_d;
            spill_keep_q <= spill_keep_d;
            spill_user_q <= spill_user_d;
            ready_q      <= ready_early;
            // ready_q guarantees the skid slot is free, so an offered beat always lands somewhere.
            if (ready_q) begin
                if (m_axis_tready || !out_valid_q) begin
                    out_valid_q <= push_req;
                    if (push_req) begin
                        out_data_q <= beat_data;
                        out_keep_q <= beat_keep;
                        out_last_q <= beat_last;
                        out_user_q <= beat_user;
                    end
                end else begin
                    skid_valid_q <= push_req;
                    if (push_req) begin
                        skid_data_q <= beat_data;
                        skid_keep_q <= beat_keep;
                        skid_last_q <= beat_last;
                        skid_user_q <= beat_user;
                    end
                end
            end else if (m_axis_tready) begin
                out_valid_q  <= skid_valid_q;
                out_data_q   <= skid_data_q;
                out_keep_q   <= skid_keep_q;
                out_last_q   <= skid_last_q;
                out_user_q   <= skid_user_q;
                skid_valid_q <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tkeep  = out_keep_q;
    assign m_axis_tlast  = out_last_q;
    assign m_axis_tuser  = out_user_q;

endmodule

// File: tb/tb_axis_icrc_append.sv
// Self-checking bench for axis_icrc_append: a byte-stream model (payload ++ ICRC chopped into
// 8-byte beats) is compared against captured output beats under random stimulus and back-pressure.
module tb_axis_icrc_append;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] s_tdata = '0, s_nm_tdata = '0;
    logic [7:0]  s_tkeep = '0;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0;
    logic [0:0]  s_tuser = '0;
    logic        s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid, m_tlast;
    logic        m_tready = 1'b1;
    logic [0:0]  m_tuser;

    axis_icrc_append #(.DATA_WIDTH(64), .USER_WIDTH(1)) dut (
        .clk(clk), .rst(rst),
        .s_axis_masked_tdata(s_tdata), .s_axis_masked_tkeep(s_tkeep),
        .s_axis_masked_tvalid(s_tvalid), .s_axis_masked_tready(s_tready),
        .s_axis_masked_tlast(s_tlast), .s_axis_masked_tuser(s_tuser),
        .s_axis_not_masked_tdata(s_nm_tdata),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [63:0] data; logic [7:0] keep; logic last; logic [0:0] user;} beat_t;
    typedef struct packed {logic [63:0] m; logic [63:0] p; logic [7:0] keep; logic last; logic [0:0] user;} in_beat_t;

    beat_t      exp_q[$], cap_q[$];
    in_beat_t   in_q[$];
    logic [7:0] msg_p[$], msg_m[$];
    logic [31:0] last_icrc;
    int errors = 0, checks = 0, stall_err = 0;
    bit rand_ready = 0, hold_ready = 0, prev_stall = 0;
    beat_t prev_beat;

    always @(posedge clk) begin
        #1;
        m_tready = hold_ready ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    always @(negedge clk) begin
        beat_t cur;
        cur.data = m_tdata; cur.keep = m_tkeep; cur.last = m_tlast; cur.user = m_tuser;
        if (rst) prev_stall = 0;
        else begin
            if (prev_stall && (!m_tvalid || cur !== prev_beat)) stall_err++;
            if (m_tvalid && m_tready) cap_q.push_back(cur);
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = cur;
        end
    end

    function automatic logic [31:0] crc_ref_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 8; k++) r = (r[0] ^ b[k]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic clear_q();
        exp_q.delete(); cap_q.delete(); in_q.delete();
    endtask

    task automatic load_str(input string s);
        msg_p.delete(); msg_m.delete();
        for (int i = 0; i < s.len(); i++) begin msg_p.push_back(s[i]); msg_m.push_back(s[i]); end
    endtask

    task automatic load_rand(input int len, input bit masked_ff);
        msg_p.delete(); msg_m.delete();
        for (int i = 0; i < len; i++) begin
            msg_p.push_back(8'($urandom));
            msg_m.push_back(masked_ff ? 8'hFF : 8'($urandom));
        end
    endtask

    // Model: output byte stream = unmasked payload ++ ICRC, cut into 8-byte beats.
    task automatic build_pkt(input bit empty_last);
        int len, nb;
        logic [31:0] crc;
        logic [7:0] stream[$];
        logic [0:0] users[$];
        in_beat_t ib;
        beat_t ob;
        len = msg_p.size();
        nb = (len + 7) / 8;
        if (empty_last && (len % 8 == 0)) nb++;
        for (int b = 0; b < nb; b++) begin
            ib = '0;
            for (int k = 0; k < 8; k++) begin
                if (8*b + k < len) begin
                    ib.m[8*k +: 8] = msg_m[8*b + k];
                    ib.p[8*k +: 8] = msg_p[8*b + k];
                    ib.keep[k] = 1'b1;
                end
            end
            ib.last = (b == nb - 1);
            ib.user = 1'($urandom);
            users.push_back(ib.user);
            in_q.push_back(ib);
        end
        crc = 32'hFFFFFFFF;
`ifdef ICRC_DUMMY_LRH_EN
        for (int i = 0; i < 8; i++) crc = crc_ref_byte(crc, 8'hFF);
`endif
        for (int i = 0; i < len; i++) crc = crc_ref_byte(crc, msg_m[i]);
        last_icrc = ~crc;
        for (int i = 0; i < len; i++) stream.push_back(msg_p[i]);
        for (int i = 0; i < 4; i++) stream.push_back(last_icrc[8*i +: 8]);
        for (int o = 0; 8*o < stream.size(); o++) begin
            ob = '0;
            for (int k = 0; k < 8; k++) begin
                if (8*o + k < stream.size()) begin
                    ob.data[8*k +: 8] = stream[8*o + k];
                    ob.keep[k] = 1'b1;
                end
            end
            ob.last = (8*(o + 1) >= stream.size());
            ob.user = users[(o < nb) ? o : nb - 1];
            exp_q.push_back(ob);
        end
    endtask

    task automatic drive_beats(input int maxn, input bit gaps);
        in_beat_t b;
        int sent;
        bit ok;
        sent = 0;
        while (in_q.size() > 0 && (maxn < 0 || sent < maxn)) begin
            b = in_q.pop_front();
            @(posedge clk); #1;
            if (gaps && $urandom_range(0, 3) == 0) begin s_tvalid = 0; @(posedge clk); #1; end
            s_tdata = b.m; s_nm_tdata = b.p; s_tkeep = b.keep; s_tlast = b.last; s_tuser = b.user;
            s_tvalid = 1;
            ok = 0;
            for (int c = 0; c < 1000; c++) begin
                @(negedge clk);
                if (s_tready) begin ok = 1; break; end
            end
            if (!ok) begin
                checks++; errors++;
                $display("FAIL input_accept_timeout got tready=0 want 1 within 1000 cycles");
                break;
            end
            sent++;
        end
        @(posedge clk); #1;
        s_tvalid = 0;
    endtask

    task automatic wait_out();
        for (int c = 0; c < 5000 && cap_q.size() < exp_q.size(); c++) @(negedge clk);
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b want 0", s_tready); end
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_tvalid); end
        checks++; if ({m_tkeep, m_tlast, m_tuser} !== 10'd0) begin
            errors++; $display("FAIL reset_outputs got keep=%h last=%b user=%b want 0", m_tkeep, m_tlast, m_tuser);
        end
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL post_reset_tready got %b want 1", s_tready); end
    endtask

    task automatic test_check_value();
        beat_t b0, b1;
        logic [31:0] want;
        clear_q(); load_str("123456789"); build_pkt(0);
`ifdef ICRC_DUMMY_LRH_EN
        want = last_icrc;
`else
        want = 32'hCBF43926;
`endif
        drive_beats(-1, 0); wait_out();
        checks++; if (cap_q.size() != 2) begin errors++; $display("FAIL check_value_count got %0d want 2", cap_q.size()); end
        if (cap_q.size() == 2) begin
            b0 = cap_q[0]; b1 = cap_q[1];
            checks++; if (b0.last !== 1'b0) begin errors++; $display("FAIL check_value_b0_last got %b want 0", b0.last); end
            checks++; if (b1.keep !== 8'h1F) begin errors++; $display("FAIL check_value_keep got %h want 1f", b1.keep); end
            checks++; if (b1.data[39:8] !== want) begin errors++; $display("FAIL check_value_icrc got %h want %h", b1.data[39:8], want); end
            checks++; if (b1.last !== 1'b1) begin errors++; $display("FAIL check_value_last got %b want 1", b1.last); end
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL check_value_beat%0d got %h want %h", i, cap_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_spill();
        beat_t b0, b1;
        logic [31:0] want;
        clear_q(); load_str("12345678"); build_pkt(0);
`ifdef ICRC_DUMMY_LRH_EN
        want = last_icrc;
`else
        want = 32'h9AE0DAAF;
`endif
        drive_beats(-1, 0);
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL spill_tready got %b want 0", s_tready); end
        wait_out();
        checks++; if (cap_q.size() != 2) begin errors++; $display("FAIL spill_count got %0d want 2", cap_q.size()); end
        if (cap_q.size() == 2) begin
            b0 = cap_q[0]; b1 = cap_q[1];
            checks++; if ({b0.keep, b0.last} !== {8'hFF, 1'b0}) begin
                errors++; $display("FAIL spill_b0 got keep=%h last=%b want keep=ff last=0", b0.keep, b0.last);
            end
            checks++; if ({b1.keep, b1.last} !== {8'h0F, 1'b1}) begin
                errors++; $display("FAIL spill_b1 got keep=%h last=%b want keep=0f last=1", b1.keep, b1.last);
            end
            checks++; if (b1.data[31:0] !== want) begin errors++; $display("FAIL spill_icrc got %h want %h", b1.data[31:0], want); end
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL spill_beat%0d got %h want %h", i, cap_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_empty_last();
        clear_q(); load_rand(16, 0); build_pkt(1);
        drive_beats(-1, 0); wait_out();
        checks++; if (cap_q.size() != 3) begin errors++; $display("FAIL empty_last_count got %0d want 3", cap_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL empty_last_beat%0d got %h want %h", i, cap_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_masking();
        int lens[3] = '{10, 20, 37};
        clear_q();
        foreach (lens[j]) begin load_rand(lens[j], 1); build_pkt(0); end
        drive_beats(-1, 0); wait_out();
        checks++; if (cap_q.size() != exp_q.size()) begin
            errors++; $display("FAIL masking_count got %0d want %0d", cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL masking_beat%0d got %h want %h", i, cap_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random_stream();
        clear_q(); stall_err = 0;
        for (int p = 0; p < 100; p++) begin
            load_rand($urandom_range(1, 200), 0);
            build_pkt(1'($urandom));
        end
        rand_ready = 1;
        drive_beats(-1, 1); wait_out();
        rand_ready = 0;
        repeat (2) @(negedge clk);
        checks++; if (cap_q.size() != exp_q.size()) begin
            errors++; $display("FAIL random_count got %0d want %0d", cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_beat%0d got %h want %h", i, cap_q[i], exp_q[i]); end
        end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL random_stall_stable got %0d changes want 0", stall_err); end
    endtask

    task automatic test_reset_mid_packet();
        clear_q(); load_rand(24, 0); build_pkt(0);
        hold_ready = 1;
        drive_beats(2, 0);
        rst = 1;
        @(negedge clk);
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL midrst_tready got %b want 0", s_tready); end
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid got %b want 0", m_tvalid); end
        hold_ready = 0;
        clear_q(); load_rand(13, 0); build_pkt(0);
        drive_beats(-1, 0); wait_out();
        checks++; if (cap_q.size() != exp_q.size()) begin
            errors++; $display("FAIL midrst_count got %0d want %0d", cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_beat%0d got %h want %h", i, cap_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_check_value();
        test_spill();
        test_empty_last();
        test_masking();
        test_random_stream();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
